// File: rtl/b_minus_ka_sequencer_pkg.sv
// Shared encodings and default widths for the B - k*A sequencer.
package b_minus_ka_sequencer_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_KW    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/adder_subtractor_16_bit.sv
// 16-bit adder/subtractor: sum = a + (b ^ {16{sub}}) + sub; cout is the raw carry out.
module adder_subtractor_16_bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        sub,
    output logic [15:0] sum,
    output logic        cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b ^ {16{sub}}} + {16'b0, sub};

endmodule

// File: rtl/b_minus_ka_sequencer.sv
// Computes B - k*A (mod 2^16) by running one shared subtractor k times,
// with a start/busy/done handshake and a sticky borrow.
module b_minus_ka_sequencer
    import b_minus_ka_sequencer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int KW    = DEF_KW
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [KW-1:0]    k,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             borrow
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_reg_q, a_reg_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [KW-1:0]    cnt_q, cnt_d;
    logic             borrow_q, borrow_d;

    logic [WIDTH-1:0] diff;
    logic             carry;

    adder_subtractor_16_bit u_addsub (
        .a    (acc_q),
        .b    (a_reg_q),
        .sub  (1'b1),
        .sum  (diff),
        .cout (carry)
    );

    always_comb begin
        state_d  = state_q;
        a_reg_d  = a_reg_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_reg_d  = a;
                    acc_d    = b;
                    cnt_d    = k;
                    borrow_d = 1'b0;
                    state_d  = (k == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                // A subtraction borrows exactly when the adder produces no carry.
                acc_d    = diff;
                borrow_d = borrow_q | ~carry;
                cnt_d    = cnt_q - KW'(1);
                if (cnt_q == KW'(1)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_reg_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_reg_q  <= a_reg_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign result = acc_q;
    assign borrow = borrow_q;

endmodule

// File: doc/b_minus_ka_sequencer.md
Name: b_minus_ka_sequencer

Overview:
Multi-cycle controller that computes result = B - k*A (mod 2^16) by sequencing one shared 16-bit adder/subtractor through k back-to-back subtractions. It is the sequential generalisation of the combinational B - 2A block. It trades adder count for latency and provides a start/busy/done handshake so a testbench or upstream FSM can drive it. Borrow semantics match the combinational block: the sticky OR of every stage borrow.

Parameters:
WIDTH, 16, datapath width of a, b, result. Fixed at 16 to match the shared adder_subtractor_16_bit.
KW, 4, width of multiplier k. Max k = 2^KW - 1 = 15.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous, active-low reset
start  input  1  request pulse; sampled only in IDLE
a  input  WIDTH  subtrahend operand; captured on accepted start
b  input  WIDTH  minuend operand; captured on accepted start
k  input  KW  number of subtractions; captured on accepted start
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle completion pulse
result  output  WIDTH  accumulator; valid from done until next accepted start
borrow  output  1  sticky borrow; valid with result

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, result=0, borrow=0; a_reg=0, cnt=0. Takes effect immediately, mid-operation included. After release, the block idles until a new start.
- States: IDLE, RUN, DONE.
- IDLE: on an edge with start=1:
  - capture a_reg<=a, acc<=b, cnt<=k, borrow<=0.
  - go to RUN if k!=0, else go to DONE.
  - start=0 stays in IDLE; result and borrow hold their values.
- RUN: each edge does the following:
  - acc <= acc + ~a_reg + 1, through the adder with its sub input tied to 1.
  - borrow <= borrow | ~carry_out.
  - cnt <= cnt - 1.
  - when cnt==1 before the edge (the last subtraction), go to DONE.
- DONE: done=1 for exactly one cycle, busy=1. The next edge goes unconditionally to IDLE.
- Latency: with start accepted at edge E, done is high in the cycle after edge E+k, and busy falls after edge E+k+1. Total: k+1 cycles of busy.
- start while busy (RUN or DONE) is ignored. Operands are not re-sampled. start must be re-asserted in IDLE.
- Arithmetic: all wrap mod 2^16.
  - borrow=1 if any intermediate subtraction borrowed, even if later stages do not.
  - k=0 gives result=b, borrow=0.
- result is the accumulator register, registered with no combinational path from inputs. It changes during RUN; consumers sample it on done.
- a, b and k may change freely after the accepting edge.

Decomposition:
- Shared package:
  - state encoding constants: IDLE=2'b00, RUN=2'b01, DONE=2'b10.
  - WIDTH and KW defaults.
- Single sub-module instance: the existing adder_subtractor_16_bit, with operands (acc, a_reg), sub=1, and its carry out used for borrow.
- FSM, counter and registers stay in the top module. No further hierarchy.

Test Plan:
- a=32, b=7, k=2, start pulse -> after 3 cycles done=1, result=65479 (7-64 mod 2^16), borrow=1. busy high for 3 cycles.
- a=21, b=85, k=2 -> result=43, borrow=0. Then a=16, b=36, k=2 -> result=4, borrow=0. Back-to-back starts are accepted one cycle after done falls.
- a=100, b=5, k=0 -> done high the cycle after start, result=5, borrow=0, busy high for 1 cycle.
- a=1, b=20, k=15 -> 15 RUN cycles, result=5, borrow=0. Then a=1, b=10, k=15 -> result=65531, borrow=1 (sticky across the later non-borrowing stages).
- start re-asserted every cycle during a k=4 run with different a/b -> result reflects only the first operands; exactly one done per accepted start.
- rst_n pulled low mid-RUN (async, between edges) -> busy, done, result and borrow are 0 immediately. After release, a new start completes correctly.
